// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and types for the single-digit BCD adder
package bcd_pkg;

  localparam int BCD_MAX     = 9;
  localparam int BCD_CORR    = 6;
  localparam int BCD_DIGIT_W = 4;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd_pair_t;

endpackage

// File: rtl/bcd_bin5_to_bcd.sv
// rtl/bcd_bin5_to_bcd.sv - combinational 5-bit binary to two-digit BCD conversion
module bcd_bin5_to_bcd
  import bcd_pkg::*;
(
  input  logic [4:0] bin,
  output bcd_digit_t tens,
  output bcd_digit_t ones,
  output logic       carry
);

  // Values 20..31 only arise from non-BCD inputs; they get a true subtract, not a mod-16 wrap.
  always_comb begin
    tens = '0;
    ones = bin[3:0];
    if (bin >= 5'd30) begin
      tens = 4'd3;
      ones = 4'(bin - 5'd30);
    end else if (bin >= 5'd20) begin
      tens = 4'd2;
      ones = 4'(bin - 5'd20);
    end else if (bin > 5'(BCD_MAX)) begin
      tens = 4'd1;
      ones = 4'(bin + 5'(BCD_CORR));
    end
  end

  assign carry = (tens != '0);

endmodule

// File: rtl/bcd_adder_core.sv
// rtl/bcd_adder_core.sv - single-digit BCD adder with registered packed-BCD result and carry
module bcd_adder_core
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [4:0] bin;
  bcd_pair_t  pair;
  logic       carry;

  assign bin = {1'b0, a} + {1'b0, b} + {4'b0, cin};

  bcd_bin5_to_bcd u_conv (
    .bin   (bin),
    .tens  (pair.tens),
    .ones  (pair.ones),
    .carry (carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum  <= 8'h00;
      cout <= 1'b0;
    end else begin
      sum  <= pair;
      cout <= carry;
    end
  end

endmodule

// File: tb/tb_bcd_adder_core.sv
// tb/tb_bcd_adder_core.sv - self-checking bench for bcd_adder_core
module tb_bcd_adder_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [7:0] sum;
  logic       cout;

  int checks = 0;
  int errors = 0;

  logic [7:0] prev_sum;
  logic       prev_cout;
  logic       have_prev = 1'b0;

  typedef struct {
    logic [3:0] va;
    logic [3:0] vb;
    logic       vc;
    logic [7:0] es;
    logic       ec;
  } vec_t;

  vec_t vecs [11] = '{
    '{4'd3,  4'd5,  1'b0, 8'h08, 1'b0},
    '{4'd4,  4'd3,  1'b1, 8'h08, 1'b0},
    '{4'd4,  4'd1,  1'b0, 8'h05, 1'b0},
    '{4'd7,  4'd4,  1'b0, 8'h11, 1'b1},
    '{4'd4,  4'd7,  1'b1, 8'h12, 1'b1},
    '{4'd9,  4'd9,  1'b1, 8'h19, 1'b1},
    '{4'd9,  4'd0,  1'b0, 8'h09, 1'b0},
    '{4'd9,  4'd0,  1'b1, 8'h10, 1'b1},
    '{4'd12, 4'd1,  1'b1, 8'h14, 1'b1},
    '{4'd15, 4'd15, 1'b1, 8'h31, 1'b1},
    '{4'd10, 4'd10, 1'b0, 8'h20, 1'b1}
  };

  bcd_adder_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // Reference: plain decimal arithmetic on the binary sum.
  function automatic logic [8:0] model(input logic [3:0] ma, input logic [3:0] mb, input logic mc);
    int s;
    s = int'(ma) + int'(mb) + int'(mc);
    return {(s > 9) ? 1'b1 : 1'b0, 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string tag, input logic [7:0] os, input logic [7:0] es,
                       input logic oc, input logic ec);
    checks++;
    assert (os === es) else begin
      errors++;
      $error("FAIL %s sum: observed %h expected %h", tag, os, es);
    end
    checks++;
    assert (oc === ec) else begin
      errors++;
      $error("FAIL %s cout: observed %b expected %b", tag, oc, ec);
    end
  endtask

  // Drive one cycle; confirm the old result holds until the edge, then the new one appears.
  task automatic step(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                      input logic trst, input logic [7:0] es, input logic ec, input string tag);
    a     = ta;
    b     = tb;
    cin   = tc;
    rst_n = trst;
    #3;
    if (have_prev) check({tag, "/hold"}, sum, prev_sum, cout, prev_cout);
    @(posedge clk);
    #1;
    if (!trst) check(tag, sum, 8'h00, cout, 1'b0);
    else       check(tag, sum, es, cout, ec);
    prev_sum  = trst ? es : 8'h00;
    prev_cout = trst ? ec : 1'b0;
    have_prev = 1'b1;
  endtask

  task automatic step_model(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                            input logic trst, input string tag);
    logic [8:0] m;
    m = model(ta, tb, tc);
    step(ta, tb, tc, trst, m[7:0], m[8], tag);
  endtask

  initial begin
    a = 4'd9; b = 4'd9; cin = 1'b1; rst_n = 1'b0;

    step(4'd9, 4'd9, 1'b1, 1'b0, 8'h00, 1'b0, "reset0");
    step(4'd9, 4'd9, 1'b1, 1'b0, 8'h00, 1'b0, "reset1");

    for (int i = 0; i < 11; i++)
      step(vecs[i].va, vecs[i].vb, vecs[i].vc, 1'b1, vecs[i].es, vecs[i].ec,
           $sformatf("dir%0d", i));

    for (int i = 0; i < 11; i++) begin
      if (i == 5)
        step(vecs[i].va, vecs[i].vb, vecs[i].vc, 1'b0, 8'h00, 1'b0, "b2b_rst");
      step(vecs[i].va, vecs[i].vb, vecs[i].vc, 1'b1, vecs[i].es, vecs[i].ec,
           $sformatf("b2b%0d", i));
    end

    for (int i = 0; i < 512; i++) begin
      logic [8:0] iv;
      iv = 9'(i);
      step_model(iv[8:5], iv[4:1], iv[0], 1'b1, $sformatf("sweep%0d", i));
    end

    for (int i = 0; i < 200; i++) begin
      logic [3:0] ra;
      logic [3:0] rb;
      logic       rc;
      logic       rr;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 15) != 0);
      step_model(ra, rb, rc, rr, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
